game_controller: RTL
====================

Name: game_controller

Overview:
Top-level game sequencer for the Flappy Bird design. Owns the game state (idle/play/dying/over) and gates the bird physics datapath via a physics tick and a hold-reset. Enables the pipe scroller, detects bird collisions against screen bounds and the active pipe, and keeps current and high score for the display logic.

Parameters:
TICK_DIV, 500000, clk cycles per physics tick (10 ms at 50 MHz)
POS_MIN, 40, top bound of bird_y; bird_y <= POS_MIN is a collision
POS_MAX, 479, ground; bird_y >= POS_MAX is a collision
BIRD_X, 100, fixed left column of bird sprite
BIRD_SIZE, 16, bird sprite width/height in pixels
PIPE_W, 40, pipe width in pixels
GAP_SIZE, 120, vertical gap height in pixels
DEATH_TICKS, 100, ticks spent in DYING before OVER
SCORE_W, 10, score counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
button_pressed  in  1  raw jump/start button, asynchronous to clk
bird_y  in  10  current bird top y from physics block
pipe_x  in  10  left x of active pipe
pipe_gap_y  in  10  top y of pipe gap
pipe_valid  in  1  pipe on screen
physics_tick  out  1  one-clk pulse, advances physics
physics_reset  out  1  holds bird at start position/velocity 0
pipe_run  out  1  pipe scroller enable
state  out  2  0 IDLE, 1 PLAY, 2 DYING, 3 OVER
score  out  SCORE_W  current score
high_score  out  SCORE_W  best score since reset
flash  out  1  bird blink during DYING

Behaviour:
- Reset (async, immediate): state=IDLE, score=0, high_score=0, tick counter=0, physics_tick=0, physics_reset=1, pipe_run=0, flash=0, scored flag=0, sync/edge flops=0.
- Button: 2-flop synchronizer then rising-edge detect. press = 1-clk pulse, 3 clk after input rise. A held button yields one press only.
- Tick gen: counter runs only in PLAY and DYING. It wraps at TICK_DIV-1, pulsing physics_tick for that cycle. Counter clears on entry to PLAY.
- IDLE: physics_reset=1, pipe_run=0. On press: go to PLAY next clk and clear score.
- PLAY: physics_reset=0, pipe_run=1. Collision is evaluated every clk from registered inputs.
  - Bound hit: bird_y <= POS_MIN or bird_y >= POS_MAX.
  - Pipe hit requires all of:
    - pipe_valid;
    - pipe_x <= BIRD_X+BIRD_SIZE-1;
    - pipe_x+PIPE_W > BIRD_X, computed at 11 bits;
    - bird_y < pipe_gap_y or bird_y+BIRD_SIZE > pipe_gap_y+GAP_SIZE.
  - Any hit: go to DYING next clk.
- Scoring (PLAY only):
  - When pipe_valid, pipe_x+PIPE_W < BIRD_X and scored=0: score+=1 (saturating at all-ones), scored=1.
  - scored clears when pipe_x+PIPE_W >= BIRD_X or pipe_valid=0.
- Simultaneous hit and score in same clk: hit wins, no increment. Ground and pipe hit together: single DYING entry.
- DYING: pipe_run=0, physics_tick continues so the bird falls. Presses are ignored. flash toggles every 8 ticks. After DEATH_TICKS ticks, go to OVER with flash=0.
- OVER: on entry clk, high_score <= max(high_score, score). Tick counter is stopped. A press goes to IDLE, and a further press is needed to play.
- rst asserted mid-game: immediate IDLE, and high_score is lost.

Optional Feature:
GOD_MODE_EN: when defined, pipe-hit terms are forced 0 and only bound hits cause DYING. Scoring is unchanged. When undefined, behaviour is exactly as above.

Decomposition:
- Package game_pkg: state encoding localparams (IDLE/PLAY/DYING/OVER), screen constants (POS_MIN, POS_MAX, BIRD_X, BIRD_SIZE, PIPE_W, GAP_SIZE), TICK_DIV default.
- One sub-module: tick_gen (enable, sync clear, TICK_DIV param, 1-clk pulse out), reused by the pipe scroller later.

Test Plan:
1. Reset, then button held high 10 clk -> one press, PLAY entered 4 clk after rise; score=0, physics_reset=0, pipe_run=1.
2. TICK_DIV=4 in PLAY, no collision -> physics_tick pulses every 4th clk; none in IDLE/OVER.
3. PLAY, bird_y=200, pipe_gap_y=150, pipe_x swept 200 down to 40 -> no hit. At pipe_x+PIPE_W=99, score=1 exactly once.
4. PLAY, bird_y=479 -> DYING next clk, pipe_run=0. flash toggles. After DEATH_TICKS ticks, OVER with high_score=score.
5. Hit and score condition in same clk -> DYING, score unchanged. With GOD_MODE_EN, pipe overlap gives no DYING.
6. rst pulsed in DYING -> state=0, score=0, high_score=0 same cycle, no physics_tick afterwards.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: state encoding, screen geometry and timing defaults for the game controller
package game_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, DYING, OVER} state_t;
  localparam int TICK_DIV_DEF = 500000;
  localparam int DEATH_TICKS_DEF = 100;
  localparam int POS_MIN = 40;
  localparam int POS_MAX = 479;
  localparam int BIRD_X = 100;
  localparam int BIRD_SIZE = 16;
  localparam int PIPE_W = 40;
  localparam int GAP_SIZE = 120;
  localparam int SCORE_W = 10;
endpackage

// File: rtl/game_controller_if.sv
// game_controller_if: button, physics/pipe inputs and game status outputs of the sequencer
interface game_controller_if;
  import game_pkg::*;
  logic button_pressed;
  logic [9:0] bird_y;
  logic [9:0] pipe_x;
  logic [9:0] pipe_gap_y;
  logic pipe_valid;
  logic physics_tick;
  logic physics_reset;
  logic pipe_run;
  logic [1:0] state;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic flash;
  modport master(
    input button_pressed, bird_y, pipe_x, pipe_gap_y, pipe_valid,
    output physics_tick, physics_reset, pipe_run, state, score, high_score, flash
  );
  modport slave(
    output button_pressed, bird_y, pipe_x, pipe_gap_y, pipe_valid,
    input physics_tick, physics_reset, pipe_run, state, score, high_score, flash
  );
endinterface

// File: rtl/game_controller_tick_gen.sv
// tick_gen: free-running divider with enable and sync clear, one-clk pulse on wrap
module tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = enable && cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/game_controller.sv
// game_controller: Flappy Bird game sequencer; define GOD_MODE_EN to disable pipe collisions
module game_controller
  import game_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DEATH_TICKS = DEATH_TICKS_DEF
) (
  input logic clk,
  input logic rst,
  game_controller_if.master bus
);
  localparam int DL = $clog2(DEATH_TICKS + 1);
  localparam int DW = DL < 4 ? 4 : DL;
  state_t st, st_nx;
  logic s1, s2, s3, press;
  logic [9:0] by, px, gy;
  logic pv;
  logic [10:0] px_end;
  logic bound_hit, pipe_hit, hit, pass, inc, scored, tick, run, last;
  logic [SCORE_W-1:0] score, high_score;
  logic [DW-1:0] dcnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {s1, s2, s3, press} <= '0;
      {by, px, gy, pv} <= '0;
    end else begin
      s1 <= bus.button_pressed;
      s2 <= s1;
      s3 <= s2;
      press <= s2 & ~s3;
      by <= bus.bird_y;
      px <= bus.pipe_x;
      gy <= bus.pipe_gap_y;
      pv <= bus.pipe_valid;
    end
  assign px_end = {1'b0, px} + 11'(PIPE_W);
  assign bound_hit = by <= 10'(POS_MIN) || by >= 10'(POS_MAX);
`ifdef GOD_MODE_EN
  assign pipe_hit = 1'b0;
`else
  logic [10:0] by_end, gy_end;
  assign by_end = {1'b0, by} + 11'(BIRD_SIZE);
  assign gy_end = {1'b0, gy} + 11'(GAP_SIZE);
  assign pipe_hit = pv && px <= 10'(BIRD_X + BIRD_SIZE - 1) && px_end > 11'(BIRD_X) && (by < gy || by_end > gy_end);
`endif
  assign hit = bound_hit || pipe_hit;
  assign pass = pv && px_end < 11'(BIRD_X);
  assign inc = st == PLAY && !hit && pass && !scored;
  assign run = st == PLAY || st == DYING;
  assign last = tick && dcnt == DW'(DEATH_TICKS - 1);
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk), .rst(rst), .enable(run), .clear(st == IDLE && press), .tick(tick)
  );
  always_comb begin
    st_nx = st;
    st_nx = (st == IDLE && press) ? PLAY :
            (st == PLAY && hit) ? DYING :
            (st == DYING && last) ? OVER :
            (st == OVER && press) ? IDLE : st;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      score <= '0;
      high_score <= '0;
      scored <= 1'b0;
      dcnt <= '0;
    end else begin
      st <= st_nx;
      if (st == IDLE && press) score <= '0;
      else if (inc) score <= &score ? score : score + 1'b1;
      scored <= pass && (scored || inc);
      dcnt <= st == DYING ? dcnt + DW'(tick) : '0;
      if (st == DYING && last && score > high_score) high_score <= score;
    end
  assign bus.physics_tick = tick;
  assign bus.physics_reset = st == IDLE;
  assign bus.pipe_run = st == PLAY;
  assign bus.state = st;
  assign bus.score = score;
  assign bus.high_score = high_score;
  assign bus.flash = st == DYING && dcnt[3];
endmodule
